// File: rtl/pc_gen_unit.sv
// Registered next-PC generator: owns the fetch PC, arbitrates trap > mret > branch/jump > sequential,
// and holds one pending redirect while fetch is stalled.
module pc_gen_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              PC_INC    = 4,
    parameter int              VECTORED  = 1,
    parameter int              CAUSE_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic               jump_en_i,
    input  logic [XLEN-1:0]    alu_target_i,
    input  logic               mret_i,
    input  logic [XLEN-1:0]    epc_i,
    input  logic               trap_i,
    input  logic               trap_irq_i,
    input  logic [CAUSE_W-1:0] trap_cause_i,
    input  logic [XLEN-1:0]    mtvec_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               pc_valid_o,
    output logic               redirect_o,
    output logic               misalign_o,
    output logic [XLEN-1:0]    misalign_addr_o,
    output logic [1:0]         dbg_state_o
);

    // Fetch interface: pc_o is offered whenever pc_valid_o=1; the consumer holds it by
    // raising stall_i, and the PC only moves on a cycle where stall_i=0.

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Redirect priority codes; 0 means no usable redirect this cycle.
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BRJ  = 2'd1;
    localparam logic [1:0] PRIO_MRET = 2'd2;
    localparam logic [1:0] PRIO_TRAP = 2'd3;

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redir_q, redir_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]      pend_prio_q, pend_prio_d;

    logic [XLEN-1:0] trap_base, trap_tgt, epc_tgt, seq_tgt, in_tgt;
    logic [1:0]      in_prio;
    logic            brj, brj_misaligned, mis_hit, in_wins;

    assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};
    assign trap_tgt  = (VECTORED != 0 && trap_irq_i)
                     ? trap_base + {{(XLEN-CAUSE_W-2){1'b0}}, trap_cause_i, 2'b00}
                     : trap_base;
    assign epc_tgt   = {epc_i[XLEN-1:2], 2'b00};
    assign seq_tgt   = pc_q + INC;

    assign brj            = br_taken_i | jump_en_i;
    assign brj_misaligned = brj && (alu_target_i[1:0] != 2'b00);
    // A misaligned branch/jump only matters when nothing of higher priority is present.
    assign mis_hit        = !trap_i && !mret_i && brj_misaligned;

    always_comb begin
        in_prio = PRIO_NONE;
        in_tgt  = seq_tgt;
        if (trap_i) begin
            in_prio = PRIO_TRAP;
            in_tgt  = trap_tgt;
        end else if (mret_i) begin
            in_prio = PRIO_MRET;
            in_tgt  = epc_tgt;
        end else if (brj && !brj_misaligned) begin
            in_prio = PRIO_BRJ;
            in_tgt  = alu_target_i;
        end
    end

    assign in_wins = (in_prio != PRIO_NONE) && (in_prio >= pend_prio_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        redir_d     = 1'b0;
        mis_d       = 1'b0;
        mis_addr_d  = mis_addr_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (stall_i) begin
                    if (in_prio != PRIO_NONE) begin
                        pend_tgt_d  = in_tgt;
                        pend_prio_d = in_prio;
                        state_d     = ST_PEND;
                    end
                end else begin
                    pc_d    = in_tgt;
                    redir_d = (in_prio != PRIO_NONE);
                    if (mis_hit) begin
                        mis_d      = 1'b1;
                        mis_addr_d = alu_target_i;
                    end
                end
            end
            ST_PEND: begin
                if (stall_i) begin
                    if (in_wins) begin
                        pend_tgt_d  = in_tgt;
                        pend_prio_d = in_prio;
                    end
                end else begin
                    pc_d        = in_wins ? in_tgt : pend_tgt_q;
                    redir_d     = 1'b1;
                    pend_prio_d = PRIO_NONE;
                    state_d     = ST_RUN;
                    if (mis_hit) begin
                        mis_d      = 1'b1;
                        mis_addr_d = alu_target_i;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VEC;
            valid_q     <= 1'b0;
            redir_q     <= 1'b0;
            mis_q       <= 1'b0;
            mis_addr_q  <= '0;
            pend_tgt_q  <= '0;
            pend_prio_q <= PRIO_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            redir_q     <= redir_d;
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = valid_q;
    assign redirect_o      = redir_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a behavioural next-PC model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pc_gen_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] alu_target_i = '0;
    logic        mret_i = 1'b0;
    logic [31:0] epc_i = '0;
    logic        trap_i = 1'b0;
    logic        trap_irq_i = 1'b0;
    logic [4:0]  trap_cause_i = '0;
    logic [31:0] mtvec_i = '0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        redirect_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int failures = 0;

    pc_gen_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .jump_en_i(jump_en_i), .alu_target_i(alu_target_i),
        .mret_i(mret_i), .epc_i(epc_i), .trap_i(trap_i), .trap_irq_i(trap_irq_i),
        .trap_cause_i(trap_cause_i), .mtvec_i(mtvec_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .redirect_o(redirect_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model: what the outputs must be, from the redirect rules
    logic [31:0] exp_pc, exp_mis_addr, m_pend_tgt;
    logic        exp_valid, exp_redir, exp_mis, m_booting;
    int          m_pend_pr;

    function automatic void source(output int pr, output logic [31:0] tgt, output bit mis);
        logic [31:0] base;
        base = {mtvec_i[31:2], 2'b00};
        pr = 0; tgt = '0; mis = 0;
        if (trap_i) begin
            pr = 3;
            tgt = trap_irq_i ? base + 32'(trap_cause_i) * 4 : base;
        end else if (mret_i) begin
            pr = 2;
            tgt = epc_i & ~32'h3;
        end else if (br_taken_i || jump_en_i) begin
            if (alu_target_i % 4 != 0) mis = 1;
            else begin pr = 1; tgt = alu_target_i; end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int pr;
        logic [31:0] tgt;
        bit mis;
        if (!rst_n) begin
            exp_pc = 32'h0; exp_valid = 0; exp_redir = 0; exp_mis = 0; exp_mis_addr = 0;
            m_booting = 1; m_pend_pr = 0; m_pend_tgt = 0;
        end else if (m_booting) begin
            m_booting = 0; exp_valid = 1; exp_redir = 0; exp_mis = 0;
        end else begin
            source(pr, tgt, mis);
            exp_redir = 0; exp_mis = 0;
            if (stall_i) begin
                if (pr > 0 && pr >= m_pend_pr) begin m_pend_pr = pr; m_pend_tgt = tgt; end
            end else begin
                if (pr > 0 && pr >= m_pend_pr) begin exp_pc = tgt; exp_redir = 1; end
                else if (m_pend_pr > 0) begin exp_pc = m_pend_tgt; exp_redir = 1; end
                else exp_pc = exp_pc + 32'd4;
                if (mis) begin exp_mis = 1; exp_mis_addr = alu_target_i; end
                m_pend_pr = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every cycle, away from the active edge
    always @(negedge clk) begin
        chk("m_pc", pc_o, exp_pc);
        chk("m_valid", 32'(pc_valid_o), 32'(exp_valid));
        chk("m_redirect", 32'(redirect_o), 32'(exp_redir));
        chk("m_misalign", 32'(misalign_o), 32'(exp_mis));
        chk("m_mis_addr", misalign_addr_o, exp_mis_addr);
    end

    // driver tasks
    task automatic clr();
        stall_i = 0; br_taken_i = 0; jump_en_i = 0; alu_target_i = 0; mret_i = 0;
        epc_i = 0; trap_i = 0; trap_irq_i = 0; trap_cause_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        clr();
        mtvec_i = 32'h0000_8001;
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", 32'(pc_valid_o), 32'h0);

        // 1: boot sequence
        release_reset();
        chk("boot_valid0", 32'(pc_valid_o), 32'h0);
        tick();
        chk("boot_pc1", pc_o, 32'h0);
        chk("boot_valid1", 32'(pc_valid_o), 32'h1);
        tick(); chk("seq_4", pc_o, 32'h4);
        tick(); chk("seq_8", pc_o, 32'h8);
        tick(); chk("seq_c", pc_o, 32'hC);

        // 2: mret beats branch
        br_taken_i = 1; alu_target_i = 32'h100; mret_i = 1; epc_i = 32'h203;
        tick();
        chk("mret_pc", pc_o, 32'h200);
        chk("mret_redir", 32'(redirect_o), 32'h1);
        tick();
        chk("mret_seq", pc_o, 32'h204);
        chk("mret_redir_off", 32'(redirect_o), 32'h0);

        // 3: vectored interrupt and exception
        trap_i = 1; trap_irq_i = 1; trap_cause_i = 5'd7;
        tick(); chk("irq_vec", pc_o, 32'h801C);
        trap_i = 1; trap_irq_i = 0; trap_cause_i = 5'd2; jump_en_i = 1; alu_target_i = 32'h103;
        tick();
        chk("exc_base", pc_o, 32'h8000);
        chk("exc_no_mis", 32'(misalign_o), 32'h0);

        // 4: stalled jump replaced by trap
        mtvec_i = 32'h0000_9000;
        stall_i = 1; jump_en_i = 1; alu_target_i = 32'h40;
        tick();
        stall_i = 1; trap_i = 1;
        tick();
        chk("stall_hold", pc_o, 32'h8000);
        chk("stall_redir", 32'(redirect_o), 32'h0);
        stall_i = 1;
        tick();
        tick();
        chk("pend_trap", pc_o, 32'h9000);
        chk("pend_redir", 32'(redirect_o), 32'h1);
        tick(); chk("pend_after", pc_o, 32'h9004);

        // lower priority dropped while pending
        mtvec_i = 32'h0000_A000;
        stall_i = 1; trap_i = 1;
        tick();
        stall_i = 1; jump_en_i = 1; alu_target_i = 32'h40;
        tick();
        tick(); chk("pend_drop", pc_o, 32'hA000);

        // redirect on release cycle overrides pending jump
        stall_i = 1; jump_en_i = 1; alu_target_i = 32'h60;
        tick();
        mret_i = 1; epc_i = 32'h300;
        tick(); chk("release_override", pc_o, 32'h300);

        // 5: misaligned jump
        jump_en_i = 1; alu_target_i = 32'h1C;
        tick(); chk("jmp_1c", pc_o, 32'h1C);
        tick(); chk("pc_20", pc_o, 32'h20);
        jump_en_i = 1; alu_target_i = 32'h102;
        tick();
        chk("mis_pc", pc_o, 32'h24);
        chk("mis_pulse", 32'(misalign_o), 32'h1);
        chk("mis_addr", misalign_addr_o, 32'h102);
        chk("mis_no_redir", 32'(redirect_o), 32'h0);
        tick();
        chk("mis_pulse_end", 32'(misalign_o), 32'h0);
        chk("mis_addr_hold", misalign_addr_o, 32'h102);

        // 6: wrap, then reset while pending
        jump_en_i = 1; alu_target_i = 32'hFFFF_FFFC;
        tick(); chk("wrap_top", pc_o, 32'hFFFF_FFFC);
        tick(); chk("wrap_zero", pc_o, 32'h0);
        stall_i = 1; jump_en_i = 1; alu_target_i = 32'h80;
        tick();
        rst_n = 0;
        #1;
        chk("pend_rst_pc", pc_o, 32'h0);
        chk("pend_rst_valid", 32'(pc_valid_o), 32'h0);
        release_reset();
        jump_en_i = 1; alu_target_i = 32'h500;
        tick();
        chk("reboot_pc", pc_o, 32'h0);
        chk("reboot_valid", 32'(pc_valid_o), 32'h1);
        tick(); chk("reboot_seq", pc_o, 32'h4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
